// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational hit path, single outstanding line fill,
// round-robin replacement per set, whole-cache flush with in-flight fill drop.
module icache_sa #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned LINE_WORDS = 16,
   parameter int unsigned SETS       = 64,
   parameter int unsigned WAYS       = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     cpu_addr_valid,
   input  logic [ADDR_W-1:0]        cpu_addr,
   output logic                     cpu_read_data_ready,
   output logic [31:0]              cpu_read_data,
   output logic                     mem_addr_valid,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic                     mem_read_data_ready,
   input  logic [LINE_WORDS*32-1:0] mem_read_data
);
   localparam int unsigned OFF_W = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned LO    = OFF_W + 2;
   localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W - 2;
   localparam int unsigned PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t             r_state;
   logic               r_drop;
   logic               r_mem_addr_valid;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [WAYS-1:0]    r_valid   [SETS];
   logic [PTR_W-1:0]   r_ptr     [SETS];
   logic [TAG_W-1:0]   r_tag_arr [SETS][WAYS];
   logic [31:0]        r_data_arr[SETS][WAYS][LINE_WORDS];

   logic [OFF_W-1:0]   w_word;
   logic [IDX_W-1:0]   w_set;
   logic [TAG_W-1:0]   w_tag;
   logic [IDX_W-1:0]   w_fill_set;
   logic [TAG_W-1:0]   w_fill_tag;
   logic               w_hit;
   logic [31:0]        w_rdata;
   logic [PTR_W-1:0]   w_victim;
   logic               w_evict;
   logic               w_install;
   logic               w_unused;

   assign w_word     = cpu_addr[OFF_W+1:2];
   assign w_set      = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
   assign w_tag      = cpu_addr[ADDR_W-1:OFF_W+IDX_W+2];
   assign w_fill_set = r_mem_addr[OFF_W+IDX_W+1:OFF_W+2];
   assign w_fill_tag = r_mem_addr[ADDR_W-1:OFF_W+IDX_W+2];
   assign w_unused   = ^cpu_addr[1:0];

   // Tag compare across the ways of the requested set; at most one way matches.
   always_comb begin
      w_hit   = 1'b0;
      w_rdata = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (r_valid[w_set][w] && (r_tag_arr[w_set][w] == w_tag)) begin
            w_hit   = 1'b1;
            w_rdata = r_data_arr[w_set][w][w_word];
         end
      end
   end

   assign cpu_read_data_ready = cpu_addr_valid && w_hit;
   assign cpu_read_data       = cpu_read_data_ready ? w_rdata : 32'h0;
   assign mem_addr_valid      = r_mem_addr_valid;
   assign mem_addr            = r_mem_addr;

   // Victim: lowest invalid way, otherwise the set's round-robin pointer.
   always_comb begin
      w_victim = r_ptr[w_fill_set];
      w_evict  = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w_fill_set][w]) begin
            w_victim = PTR_W'(w);
            w_evict  = 1'b0;
         end
      end
   end

   assign w_install = (r_state == S_REQ) && mem_read_data_ready && !r_drop && !flush;

   always_ff @(posedge clk) begin
      if (w_install) begin
         r_tag_arr[w_fill_set][w_victim] <= w_fill_tag;
         for (int k = 0; k < LINE_WORDS; k++)
            r_data_arr[w_fill_set][w_victim][k] <= mem_read_data[k*32 +: 32];
      end
   end

   // Miss FSM plus valid bits and replacement pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= S_IDLE;
         r_drop           <= 1'b0;
         r_mem_addr_valid <= 1'b0;
         r_mem_addr       <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_valid[s] <= '0;
            r_ptr[s]   <= '0;
         end
      end else begin
         if (flush) begin
            for (int s = 0; s < SETS; s++)
               r_valid[s] <= '0;
         end
         case (r_state)
            S_IDLE: begin
               if (cpu_addr_valid && !w_hit) begin
                  r_mem_addr       <= {cpu_addr[ADDR_W-1:LO], {LO{1'b0}}};
                  r_mem_addr_valid <= 1'b1;
                  r_state          <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_read_data_ready) begin
                  r_state          <= S_IDLE;
                  r_mem_addr_valid <= 1'b0;
                  r_drop           <= 1'b0;
                  if (w_install) begin
                     r_valid[w_fill_set][w_victim] <= 1'b1;
                     if (w_evict && (WAYS > 1))
                        r_ptr[w_fill_set] <= r_ptr[w_fill_set] + PTR_W'(1);
                  end
               end else if (flush) begin
                  // Fill in flight predates the flush; its data must not be installed.
                  r_drop <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
